// File: rtl/step_pkg.sv
// Shared types and defaults for the step burst scheduler.
package step_pkg;

    localparam int unsigned STEP_CNT_W   = 8;
    localparam int unsigned STEP_GAP_CYC = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } step_state_e;

    // Width needed to index n items, never less than one bit.
    function automatic int unsigned step_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or above ptr, with wrap-around.
module rr_arbiter
    import step_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = step_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [ID_W-1:0]    grant_id_c
);

    logic          found;
    int unsigned   idx;
    logic [ID_W-1:0] idx_w;

    always_comb begin
        grant_c    = '0;
        grant_id_c = '0;
        found      = 1'b0;
        idx        = 0;
        idx_w      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (!found && valid[idx_w]) begin
                found          = 1'b1;
                grant_c[idx_w] = 1'b1;
                grant_id_c     = idx_w;
            end
        end
    end

endmodule

// File: rtl/step_burst_sched.sv
// Round-robin scheduler emitting bursts of spaced STEP pulses for several requesters.
// Optional STEP_BURST_ABORT_EN adds an abort input and an aborted completion flag.
module step_burst_sched
    import step_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned CNT_W   = STEP_CNT_W,
    parameter int unsigned GAP_CYC = STEP_GAP_CYC,
    parameter int unsigned ID_W    = step_id_w(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*CNT_W-1:0] req_count,
`ifdef STEP_BURST_ABORT_EN
    input  logic                     abort,
`endif
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     STEP,
    output logic                     busy,
    output logic                     done,
`ifdef STEP_BURST_ABORT_EN
    output logic                     aborted,
`endif
    output logic [ID_W-1:0]          done_id
);

    localparam int unsigned GAP_W = step_id_w(GAP_CYC);

    step_state_e       state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [ID_W-1:0]   gid_q, gid_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              cut_d;
    logic              step_q, busy_q, done_q, aborted_q;
    logic [ID_W-1:0]   done_id_q;
    logic              abort_c;

    logic [NUM_REQ-1:0] gnt_c;
    logic [ID_W-1:0]    gnt_id_c;
    logic [CNT_W-1:0]   cnt_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign cnt_arr[g] = req_count[g*CNT_W +: CNT_W];
    end

`ifdef STEP_BURST_ABORT_EN
    assign abort_c = abort;
    assign aborted = aborted_q;
`else
    assign abort_c = 1'b0;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .valid      (req_valid),
        .ptr        (rr_ptr_q),
        .grant_c    (gnt_c),
        .grant_id_c (gnt_id_c)
    );

    // Commands are only offered while idle, so one acceptance per burst.
    assign req_ready = (state_q == IDLE) ? gnt_c : '0;

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        gap_d    = gap_q;
        gid_d    = gid_q;
        rr_ptr_d = rr_ptr_q;
        cut_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|gnt_c) begin
                    rem_d   = cnt_arr[gnt_id_c];
                    gid_d   = gnt_id_c;
                    state_d = (cnt_arr[gnt_id_c] == '0) ? DONE : PULSE;
                end
            end
            PULSE: begin
                rem_d = rem_q - CNT_W'(1);
                if (abort_c) begin
                    state_d = DONE;
                    cut_d   = 1'b1;
                end else if (rem_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    gap_d   = GAP_W'(GAP_CYC - 1);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (abort_c) begin
                    state_d = DONE;
                    cut_d   = 1'b1;
                end else if (gap_q == '0) begin
                    state_d = PULSE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_d  = IDLE;
                rr_ptr_d = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + ID_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            gap_q     <= '0;
            gid_q     <= '0;
            rr_ptr_q  <= '0;
            step_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            gap_q     <= gap_d;
            gid_q     <= gid_d;
            rr_ptr_q  <= rr_ptr_d;
            step_q    <= (state_d == PULSE);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            done_id_q <= (state_d == DONE) ? gid_d : '0;
            aborted_q <= cut_d;
        end
    end

    assign STEP    = step_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_step_burst_sched.sv
// Directed bench for step_burst_sched: table of single bursts plus contention, reset, max-count and abort sequences.
module tb_step_burst_sched;

    logic        CLK;
    logic        RSTn;
    logic [1:0]  valid_a, valid_b;
    logic [15:0] count_a, count_b;
    logic [1:0]  ready_a, ready_b;
    logic        step_a, step_b, busy_a, busy_b, done_a, done_b;
    logic [0:0]  done_id_a, done_id_b;
`ifdef STEP_BURST_ABORT_EN
    logic        abort_a, abort_b;
    logic        aborted_a, aborted_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    step_burst_sched #(.NUM_REQ(2), .CNT_W(8), .GAP_CYC(4), .ID_W(1)) dut_a (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .req_valid (valid_a),
        .req_count (count_a),
`ifdef STEP_BURST_ABORT_EN
        .abort     (abort_a),
`endif
        .req_ready (ready_a),
        .STEP      (step_a),
        .busy      (busy_a),
        .done      (done_a),
`ifdef STEP_BURST_ABORT_EN
        .aborted   (aborted_a),
`endif
        .done_id   (done_id_a)
    );

    step_burst_sched #(.NUM_REQ(2), .CNT_W(8), .GAP_CYC(1), .ID_W(1)) dut_b (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .req_valid (valid_b),
        .req_count (count_b),
`ifdef STEP_BURST_ABORT_EN
        .abort     (abort_b),
`endif
        .req_ready (ready_b),
        .STEP      (step_b),
        .busy      (busy_b),
        .done      (done_b),
`ifdef STEP_BURST_ABORT_EN
        .aborted   (aborted_b),
`endif
        .done_id   (done_id_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        int id;
        int cnt;
        int exp_pulses;
        int exp_done;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Submit one burst (plus optional competing requests), follow it to done and check it.
    task automatic burst(input bit sel, input int id, input int cnt, input logic [1:0] also,
                         input int exp_pulses, input int exp_done, input int period,
                         input int limit, input int abort_after);
        int pulses = 0;
        int done_c = -1;
        int got_id = -1;
        int bad_pos = 0;
        int busy1 = 0;
        int got_ab = 0;
        int rdy;
        logic [1:0] mask;
        mask = also | 2'(1 << id);
        @(negedge CLK);
        for (int r = 0; r < 2; r++) begin
            if (mask[r]) begin
                if (sel) count_b[r*8 +: 8] = 8'(cnt);
                else     count_a[r*8 +: 8] = 8'(cnt);
            end
        end
        if (sel) valid_b = mask; else valid_a = mask;
        #1;
        rdy = sel ? int'(ready_b) : int'(ready_a);
        check("grant", rdy, 1 << id);
        @(posedge CLK);
        #1;
        valid_a = '0;
        valid_b = '0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge CLK);
`ifdef STEP_BURST_ABORT_EN
            abort_a = 1'b0;
`endif
            if (c == 1) busy1 = sel ? int'(busy_b) : int'(busy_a);
            if (sel ? step_b : step_a) begin
                pulses++;
                if ((c - 1) % period != 0) bad_pos++;
`ifdef STEP_BURST_ABORT_EN
                if (!sel && abort_after != 0 && pulses == abort_after) abort_a = 1'b1;
`endif
            end
            if (sel ? done_b : done_a) begin
                done_c = c;
                got_id = sel ? int'(done_id_b) : int'(done_id_a);
`ifdef STEP_BURST_ABORT_EN
                got_ab = sel ? int'(aborted_b) : int'(aborted_a);
`endif
                break;
            end
        end
        check("pulse_count", pulses, exp_pulses);
        check("done_cycle", done_c, exp_done);
        check("done_id", got_id, id);
        check("pulse_spacing_errors", bad_pos, 0);
        check("busy_after_accept", busy1, 1);
`ifdef STEP_BURST_ABORT_EN
        check("aborted_flag", got_ab, (abort_after != 0) ? 1 : 0);
`else
        check("aborted_flag", got_ab + abort_after, 0);
`endif
        @(negedge CLK);
        check("busy_idle", sel ? int'(busy_b) : int'(busy_a), 0);
    endtask

    initial begin
        int ids [4];
        int nd;
        int viol;
        int pulses;
        int done_seen;

        tbl[0] = '{id: 0, cnt: 3, exp_pulses: 3, exp_done: 12};
        tbl[1] = '{id: 1, cnt: 0, exp_pulses: 0, exp_done: 1};
        tbl[2] = '{id: 0, cnt: 1, exp_pulses: 1, exp_done: 2};
        tbl[3] = '{id: 1, cnt: 2, exp_pulses: 2, exp_done: 7};

        RSTn    = 1'b0;
        valid_a = '0;
        valid_b = '0;
        count_a = '0;
        count_b = '0;
`ifdef STEP_BURST_ABORT_EN
        abort_a = 1'b0;
        abort_b = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        check("rst_step", int'(step_a) + int'(step_b), 0);
        check("rst_busy", int'(busy_a) + int'(busy_b), 0);
        check("rst_done", int'(done_a) + int'(done_b), 0);
        check("rst_done_id", int'(done_id_a) + int'(done_id_b), 0);
        check("rst_ready", int'(ready_a) + int'(ready_b), 0);
        RSTn = 1'b1;

        // Contention from reset: both requesters hold valid with count 2.
        @(negedge CLK);
        count_a = {8'd2, 8'd2};
        valid_a = 2'b11;
        #1;
        check("cont_first_grant", int'(ready_a), 1);
        nd = 0;
        viol = 0;
        for (int c = 0; c < 400 && nd < 4; c++) begin
            @(negedge CLK);
            if (busy_a && ready_a != 2'b00) viol++;
            if (!busy_a && ready_a == 2'b11) viol++;
            if (done_a) begin
                ids[nd] = int'(done_id_a);
                nd++;
            end
        end
        valid_a = '0;
        check("cont_done_count", nd, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < nd) check($sformatf("cont_order_%0d", i), ids[i], i % 2);
        end
        check("cont_ready_outside_idle", viol, 0);
        @(negedge CLK);

        for (int i = 0; i < 4; i++) begin
            burst(1'b0, tbl[i].id, tbl[i].cnt, 2'b00, tbl[i].exp_pulses, tbl[i].exp_done, 5, 200, 0);
        end

        // Leave rr_ptr at 1, then reset during the GAP after pulse 2 of a 5-step burst.
        burst(1'b0, 0, 1, 2'b00, 1, 2, 5, 50, 0);
        @(negedge CLK);
        count_a[15:8] = 8'd5;
        valid_a = 2'b10;
        #1;
        check("mid_grant", int'(ready_a), 2);
        @(posedge CLK);
        #1;
        valid_a = '0;
        pulses = 0;
        for (int c = 0; c < 60 && pulses < 2; c++) begin
            @(negedge CLK);
            if (step_a) pulses++;
        end
        check("mid_pulses_before_reset", pulses, 2);
        @(negedge CLK);
        check("mid_in_gap_step", int'(step_a), 0);
        RSTn = 1'b0;
        #1;
        check("mid_rst_step", int'(step_a), 0);
        check("mid_rst_busy", int'(busy_a), 0);
        check("mid_rst_done", int'(done_a), 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge CLK);
            if (done_a) done_seen++;
        end
        check("mid_rst_no_done", done_seen, 0);
        RSTn = 1'b1;
        // Both valid after release: rr_ptr must be back at 0.
        burst(1'b0, 0, 1, 2'b10, 1, 2, 5, 50, 0);

        // Largest count with minimum gap on the second instance.
        burst(1'b1, 0, 255, 2'b00, 255, 510, 2, 1200, 0);

`ifdef STEP_BURST_ABORT_EN
        burst(1'b0, 0, 10, 2'b00, 3, 12, 5, 200, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/step_burst_sched.md
Name: step_burst_sched

Overview:
- Schedules bursts of single-cycle STEP pulses on the one shared stepper-drive output.
- Sits between several motion requesters and the STEP pin.
- Each requester submits a step count through a valid/ready handshake.
- A round-robin arbiter grants one requester at a time. The block then emits that many STEP pulses at a fixed spacing and signals completion with a one-cycle done pulse tagged with the requester ID.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- CNT_W, 8, width of each requested step count.
- GAP_CYC, 4, number of low cycles between consecutive STEP pulses (>=1).
- ID_W, 1, width of done_id; must equal clog2(NUM_REQ), with a minimum of 1.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_count  in  NUM_REQ*CNT_W  packed step counts; requester i owns bits [i*CNT_W +: CNT_W].
- req_ready  out  NUM_REQ  one-hot grant; a command is accepted when valid&ready.
- STEP  out  1  registered step pulse, high for exactly one cycle per step.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- done_id  out  ID_W  requester whose burst completed; valid only while done=1.

Behaviour:
- Reset: asynchronous assert, synchronous release. On reset:
  - state=IDLE, STEP=0, busy=0, done=0, done_id=0, remaining=0, gap counter=0, rr_ptr=0.
- Reset mid-burst aborts the burst immediately. No done pulse is emitted for the aborted burst.
- States: IDLE, PULSE, GAP, DONE. State, STEP, busy, done and done_id are all registered.
- IDLE:
  - req_ready is combinational. It is one-hot for the first valid requester found searching from rr_ptr upward with wrap-around, and zero when no request is valid.
  - On acceptance at edge k:
    - latch req_count into remaining and latch the granted ID;
    - if the count is 0, go to DONE; otherwise go to PULSE.
  - STEP is therefore high in the cycle following edge k: one cycle of latency from acceptance.
- PULSE:
  - STEP=1 and remaining decrements.
  - If the decremented value is 0, go to DONE.
  - Otherwise load the gap counter with GAP_CYC-1 and go to GAP.
- GAP:
  - STEP=0. The counter decrements each cycle; at 0, go to PULSE.
  - Pulse period is therefore GAP_CYC+1 cycles.
- DONE:
  - done=1 and done_id=granted ID for exactly one cycle.
  - rr_ptr = granted ID + 1, wrapping to 0 at NUM_REQ.
  - Next state is IDLE. req_ready=0 in this cycle.
- req_ready is 0 in every state other than IDLE, so at most one command is accepted per burst.
- The minimum idle cycle between bursts is the IDLE cycle.
- Requesters must hold req_valid and req_count stable until accepted. Dropping req_valid before acceptance withdraws the request without side effects.
- Counts wrap-free: the maximum count 2^CNT_W-1 must complete exactly, with no off-by-one.
- Simultaneous requests: grant follows rr_ptr order. A requester that keeps valid high is never starved; it is served within NUM_REQ bursts.
- busy is low only in IDLE.

Optional Feature:
- Macro STEP_BURST_ABORT_EN adds input port abort (1 bit).
- With the macro defined:
  - abort=1 in PULSE or GAP sends the FSM to DONE on the next edge and forces STEP to 0 from that edge on;
  - done_id reports the aborted requester;
  - a registered output aborted (1 bit) is high alongside done when the burst was cut short;
  - abort is ignored in IDLE and DONE.
- Without the macro, neither port exists and bursts always run to completion.

Decomposition:
- Shared package step_pkg holds:
  - the state enum typedef (IDLE, PULSE, GAP, DONE);
  - default constants STEP_CNT_W=8 and STEP_GAP_CYC=4;
  - a clog2-based ID-width function.
- One sub-module, rr_arbiter: combinational round-robin grant from valid vector and pointer, parameterised by NUM_REQ.

Test Plan:
- Single request: req0 count=3, GAP_CYC=4, accepted at edge k.
  - Expect STEP high in cycles k+1, k+6 and k+11.
  - Expect done=1 with done_id=0 at cycle k+12, and exactly 3 STEP pulses.
- Zero count: req1 count=0.
  - Expect no STEP, and done=1 with done_id=1 one cycle after acceptance.
- Contention: both requesters valid continuously with count=2, starting from reset.
  - Expect grant order 0,1,0,1.
  - Expect done_id alternating, and req_ready never asserted outside IDLE.
- Max count: req0 count=255 with GAP_CYC=1.
  - Expect exactly 255 STEP pulses at period 2, then done.
- Reset mid-burst: deassert RSTn during the GAP following the 2nd of 5 pulses.
  - Expect STEP, busy and done to go 0 immediately, with no done pulse.
  - Expect a fresh count=1 request after release to complete normally with rr_ptr=0.
- With STEP_BURST_ABORT_EN: count=10, abort pulsed after the 3rd STEP.
  - Expect exactly 3 pulses, done=1 and aborted=1 on the next cycle, then IDLE.
